multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified memory, IR, A/B/ALUOut registers.
- Replaces the single-cycle opcode decoder. Opcode set is unchanged: R, lw, sw, beq, j, addi, andi, ori, slti.
- ALUOp encoding is unchanged: 010 R-funct, 011 add, 100 sub, 111 and, 101 or, 001 slt.
- Adds a memory ready handshake with a watchdog, and flags illegal opcodes.

Parameters:
MEM_TIMEOUT, 15, wait cycles with mem_ready low before abort (1..255)
CNT_W, 8, watchdog counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
OPCODE  input  6  IR[31:26], stable from DECODE onward
Zero  input  1  ALU zero flag, valid in BRANCH
mem_ready  input  1  memory completes the current MemRead/MemWrite this cycle
PCWrite  output  1  PC load enable, already qualified by Zero for beq
IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR load enable
MemToReg  output  1  0 = ALUOut, 1 = MDR to the register file
RegDst  output  1  0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
ALUOp  output  3  operation encoding as above
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse when an instruction retires
illegal  output  1  one-cycle pulse on an unsupported opcode
mem_err  output  1  one-cycle pulse on watchdog abort
state  output  4  current state, for debug

Behaviour:
- Reset (async, rst_n=0): state=FETCH, counter=0.
  - All outputs take their combinational values for FETCH with mem_ready low: MemRead=1, ALUSrcB=01, ALUOp=011.
  - Every other enable and pulse is 0.
- Outputs not listed for a state are 0. States are encoded 0..12 in the order below.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=011, PCSource=00.
  - When mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=011 (branch target computed into ALUOut). Next state by OPCODE:
  - lw/sw -> MEM_ADDR
  - R -> R_EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi/andi/ori/slti -> I_EXEC
  - anything else -> FETCH, with illegal=1 in this DECODE cycle
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=011. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ(3): MemRead=1, IorD=1. Stay until mem_ready, then MEM_WB.
- MEM_WB(4): RegWrite=1, MemToReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEM_WRITE(5): MemWrite=1, IorD=1. Stay until mem_ready; on that cycle instr_done=1 and next state FETCH.
- R_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state R_WB.
- R_WB(7): RegWrite=1, RegDst=1, MemToReg=0, instr_done=1. Next state FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01, PCWrite=Zero, instr_done=1. Next state FETCH.
- JUMP(9): PCSource=10, PCWrite=1, instr_done=1. Next state FETCH.
- I_EXEC(10): ALUSrcA=1, ALUSrcB=10. ALUOp by opcode: addi 011, andi 111, ori 101, slti 001. Next state I_WB.
- I_WB(11): same ALUSrcA/ALUSrcB/ALUOp as I_EXEC; RegWrite=1, RegDst=0, MemToReg=0, instr_done=1. Next state FETCH.
- ABORT(12): mem_err=1, all other enables 0. Next state FETCH.
- Watchdog:
  - Counter clears on every state change.
  - It increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - When counter == MEM_TIMEOUT and mem_ready=0, next state is ABORT.
  - mem_ready=1 on the terminal cycle takes priority over the timeout.
  - An abort in FETCH does not advance the PC. The instruction is re-fetched.
- Latency with zero-wait memory:
  - beq, j: 3 cycles
  - R, sw, I-type: 4 cycles
  - lw: 5 cycles
  - Each wait cycle adds 1.
- Zero is ignored outside BRANCH.
- rst_n asserted mid-instruction: immediate return to FETCH. No partial RegWrite or MemWrite may be issued after reset release.

Test Plan:
- Reset, then mem_ready held 1, R-type (OPCODE=000000) -> state 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7; instr_done pulses once at cycle 4.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. MemRead=1, IorD=1 throughout state 3; RegWrite=1 with MemToReg=1 in state 4.
- beq (000100) with Zero=1, then a second beq with Zero=0 -> first: PCWrite=1, PCSource=01 in state 8. Second: PCWrite=0 in state 8. Both take 3 cycles.
- ori (001101) then slti (001010) -> ALUOp=101 for ori and 001 for slti in states 10 and 11. ALUSrcB=10, RegDst=0.
- OPCODE=111111 -> illegal=1 in the DECODE cycle. Next state FETCH; no RegWrite, MemWrite or PCWrite beyond the fetch.
- MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH -> ABORT after 16 FETCH cycles, mem_err=1 for one cycle, then FETCH with PCWrite never asserted. Separately, async rst_n pulse during MEM_WRITE -> state=0 and MemWrite=0 before the next clock edge.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore-style sequencer for the shared multicycle MIPS
//                datapath, with a memory-ready handshake, a memory watchdog
//                and an illegal-opcode flag.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPCODE,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_ABORT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b001;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mem_wait_state;   // state that waits on mem_ready
    logic             timeout;          // watchdog expires this cycle
    logic [2:0]       imm_aluop;        // ALU operation for I-type arithmetic

    assign state          = state_q;
    assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                            (state_q == S_MEM_WRITE);
    assign timeout        = (cnt_q == TIMEOUT_VAL) && !mem_ready;

    // ALU operation selected by the immediate-type opcode
    always_comb begin
        imm_aluop = ALU_ADD;
        case (OPCODE)
            OP_ANDI: imm_aluop = ALU_AND;
            OP_ORI:  imm_aluop = ALU_OR;
            OP_SLTI: imm_aluop = ALU_SLT;
            default: imm_aluop = ALU_ADD;
        endcase
    end

    // State register and watchdog counter; reset returns straight to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control outputs for the current state
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 3'b000;
        PCSource   = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    // PC is left untouched so the same instruction is re-fetched
                    state_d = S_ABORT;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                case (OPCODE)
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_R:                             state_d = S_R_EXEC;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                state_d = (OPCODE == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_ABORT;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout) begin
                    state_d = S_ABORT;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_SUB;
                PCSource   = 2'b01;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSource   = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = imm_aluop;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = imm_aluop;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ABORT: begin
                mem_err = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Watchdog: clears on any state change, counts idle memory-wait cycles
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (mem_wait_state && !mem_ready)
            cnt_d = cnt_q + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//                Each instruction is expanded into the per-cycle control
//                words it must produce; one compare process checks them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam int TO = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OPCODE;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst;
    logic       RegWrite, ALUSrcA, instr_done, illegal, mem_err;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal(illegal),
        .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    // Control word layout:
    // PCWrite IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA
    // ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0] instr_done illegal mem_err
    wire [18:0] dut_cw = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                          instr_done, illegal, mem_err};

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic        exp_valid = 1'b0;
    logic [3:0]  exp_st;
    logic [18:0] exp_cw;
    string       exp_tag;

    function automatic logic [18:0] mk(
        input logic pcw, iord, mr, mw, irw, m2r, rd, rw, asa,
        input logic [1:0] asb, input logic [2:0] op, input logic [1:0] pcs,
        input logic done, ill, merr);
        return {pcw, iord, mr, mw, irw, m2r, rd, rw, asa, asb, op, pcs, done, ill, merr};
    endfunction

    // Per-step control words, written straight from the state descriptions
    function automatic logic [18:0] f_fetch(input logic rdy);
        return mk(rdy,0,1,0,rdy,0,0,0,0, 2'b01, 3'b011, 2'b00, 0,0,0);
    endfunction
    function automatic logic [18:0] f_dec(input logic ill);
        return mk(0,0,0,0,0,0,0,0,0, 2'b11, 3'b011, 2'b00, 0,ill,0);
    endfunction
    function automatic logic [18:0] f_maddr();
        return mk(0,0,0,0,0,0,0,0,1, 2'b10, 3'b011, 2'b00, 0,0,0);
    endfunction
    function automatic logic [18:0] f_mread();
        return mk(0,1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0,0);
    endfunction
    function automatic logic [18:0] f_mwb();
        return mk(0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 1,0,0);
    endfunction
    function automatic logic [18:0] f_mwrite(input logic rdy);
        return mk(0,1,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, rdy,0,0);
    endfunction
    function automatic logic [18:0] f_rexec();
        return mk(0,0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0,0,0);
    endfunction
    function automatic logic [18:0] f_rwb();
        return mk(0,0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 1,0,0);
    endfunction
    function automatic logic [18:0] f_branch(input logic z);
        return mk(z,0,0,0,0,0,0,0,1, 2'b00, 3'b100, 2'b01, 1,0,0);
    endfunction
    function automatic logic [18:0] f_jump();
        return mk(1,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,0,0);
    endfunction
    function automatic logic [18:0] f_iexec(input logic [2:0] op, input logic wb);
        return mk(0,0,0,0,0,0,0,wb,1, 2'b10, op, 2'b00, wb,0,0);
    endfunction
    function automatic logic [18:0] f_abort();
        return mk(0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0,1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock cycle: drive inputs, publish expectation, advance to edge+1
    task automatic cyc(input logic [3:0] st, input logic [18:0] w,
                       input logic rdy, input string tag);
        mem_ready = rdy;
        exp_st    = st;
        exp_cw    = w;
        exp_tag   = tag;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // A memory-waiting step: `waits` idle cycles, aborting after TO+1 of them
    task automatic wait_phase(input logic [3:0] st, input int waits,
                              input logic [18:0] rdy_cw, input logic [18:0] wait_cw,
                              input string tag, output logic ab);
        int n;
        n = (waits > TO) ? TO + 1 : waits;
        for (int i = 0; i < n; i++) cyc(st, wait_cw, 1'b0, tag);
        if (waits > TO) begin
            cyc(4'd12, f_abort(), 1'b0, {tag, "/abort"});
            ab = 1'b1;
        end else begin
            cyc(st, rdy_cw, 1'b1, tag);
            ab = 1'b0;
        end
    endtask

    function automatic logic [2:0] imm_op(input logic [5:0] opc);
        case (opc)
            OP_ANDI: return 3'b111;
            OP_ORI:  return 3'b101;
            OP_SLTI: return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

    // Expand one instruction into its expected cycle sequence
    task automatic instr(input logic [5:0] opc, input int fw, input int mw,
                         input logic z, input string nm);
        logic ab;
        OPCODE = opc;
        Zero   = z;
        wait_phase(4'd0, fw, f_fetch(1'b1), f_fetch(1'b0), {nm, "/fetch"}, ab);
        if (ab) return;
        case (opc)
            OP_LW: begin
                cyc(4'd1, f_dec(1'b0), 1'b1, {nm, "/decode"});
                cyc(4'd2, f_maddr(), 1'b1, {nm, "/addr"});
                wait_phase(4'd3, mw, f_mread(), f_mread(), {nm, "/read"}, ab);
                if (!ab) cyc(4'd4, f_mwb(), 1'b1, {nm, "/wb"});
            end
            OP_SW: begin
                cyc(4'd1, f_dec(1'b0), 1'b1, {nm, "/decode"});
                cyc(4'd2, f_maddr(), 1'b1, {nm, "/addr"});
                wait_phase(4'd5, mw, f_mwrite(1'b1), f_mwrite(1'b0), {nm, "/write"}, ab);
            end
            OP_R: begin
                cyc(4'd1, f_dec(1'b0), 1'b1, {nm, "/decode"});
                cyc(4'd6, f_rexec(), 1'b1, {nm, "/exec"});
                cyc(4'd7, f_rwb(), 1'b1, {nm, "/wb"});
            end
            OP_BEQ: begin
                cyc(4'd1, f_dec(1'b0), 1'b1, {nm, "/decode"});
                cyc(4'd8, f_branch(z), 1'b1, {nm, "/branch"});
            end
            OP_J: begin
                cyc(4'd1, f_dec(1'b0), 1'b1, {nm, "/decode"});
                cyc(4'd9, f_jump(), 1'b1, {nm, "/jump"});
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                cyc(4'd1, f_dec(1'b0), 1'b1, {nm, "/decode"});
                cyc(4'd10, f_iexec(imm_op(opc), 1'b0), 1'b1, {nm, "/exec"});
                cyc(4'd11, f_iexec(imm_op(opc), 1'b1), 1'b1, {nm, "/wb"});
            end
            default: cyc(4'd1, f_dec(1'b1), 1'b1, {nm, "/decode"});
        endcase
    endtask

    // Compare process: DUT state and control word against the expectation
    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (state === exp_st && dut_cw === exp_cw) n_pass++;
            else $display("FAIL %s: state=%0d cw=%b expected state=%0d cw=%b",
                          exp_tag, state, dut_cw, exp_st, exp_cw);
        end
        if (rst_n === 1'b1 && instr_done === 1'b1) done_cnt++;
        if (rst_n === 1'b1 && mem_err === 1'b1) err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; mem_ready = 1'b0; OPCODE = 6'd0; Zero = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_MemRead", 32'(MemRead), 32'd1);
        chk("reset_ALUSrcB", 32'(ALUSrcB), 32'd1);
        chk("reset_ALUOp", 32'(ALUOp), 32'd3);
        chk("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal, mem_err}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        instr(OP_R,    0, 0, 1'b1, "r_type");
        instr(OP_LW,   0, 2, 1'b0, "lw_wait2");
        instr(OP_BEQ,  0, 0, 1'b1, "beq_taken");
        instr(OP_BEQ,  0, 0, 1'b0, "beq_not_taken");
        instr(OP_ORI,  0, 0, 1'b1, "ori");
        instr(OP_SLTI, 0, 0, 1'b0, "slti");
        instr(6'b111111, 0, 0, 1'b1, "illegal");
        instr(OP_J,    TO + 1, 0, 1'b0, "fetch_stuck");
        instr(OP_J,    0, 0, 1'b0, "j_refetch");
        instr(OP_SW,   1, 1, 1'b1, "sw_wait1");
        instr(OP_ADDI, 0, 0, 1'b0, "addi");
        instr(OP_ANDI, 2, 0, 1'b1, "andi");
        instr(OP_J,    0, 0, 1'b1, "j");
        instr(OP_R,    TO, 0, 1'b0, "fetch_ready_at_limit");
        instr(OP_LW,   0, TO + 1, 1'b0, "lw_read_stuck");

        // Asynchronous reset while a store is waiting in MEM_WRITE
        OPCODE = OP_SW; Zero = 1'b0;
        cyc(4'd0, f_fetch(1'b1), 1'b1, "swrst/fetch");
        cyc(4'd1, f_dec(1'b0), 1'b1, "swrst/decode");
        cyc(4'd2, f_maddr(), 1'b1, "swrst/addr");
        cyc(4'd5, f_mwrite(1'b0), 1'b0, "swrst/write");
        exp_valid = 1'b0;
        chk("swrst_pre_state", 32'(state), 32'd5);
        chk("swrst_pre_MemWrite", 32'(MemWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("swrst_state", 32'(state), 32'd0);
        chk("swrst_MemWrite", 32'(MemWrite), 32'd0);
        chk("swrst_MemRead", 32'(MemRead), 32'd1);
        #1 rst_n = 1'b1;
        instr(OP_ADDI, 0, 0, 1'b0, "addi_after_reset");

        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("instr_done_count", 32'(done_cnt), 32'd13);
        chk("mem_err_count", 32'(err_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
